hack_ctrl_seq: RTL

- Multi-cycle control sequencer for the Hack-style datapath.
- Fetches 16-bit instructions and holds the A, D and PC registers.
- Drives operands and zx/nx/zy/ny/f/no to the 16-bit ALU, and consumes the ALU's out/zr/ng to write back results and resolve jumps.
- Data memory and instruction memory are reached over req/ack handshakes.

---
 rtl/hack_ctrl_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/hack_ctrl_seq.sv
// hack_ctrl_seq: multi-cycle Hack control sequencer (FETCH, DECODE, MREAD, EXEC, MWRITE, WB) holding A, D, IR and PC.
// Latency: A-instruction 2 cycles; C-instruction 4 cycles, +1 with an M read, +1 with an M write, plus ack waits.
// Backpressure: each req is held with stable address/data until its ack; instr_req and mem_req are never high together.
// Optional macro HACK_HALT_DETECT_EN adds the halted output (unconditional self-jump parks the sequencer in FETCH).
module hack_ctrl_seq #(
    parameter int AW = 15,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    // instruction fetch port
    output logic          instr_req,
    output logic [AW-1:0] instr_addr,
    input  logic          instr_ack,
    input  logic [DW-1:0] instr_data,
    // data memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    // external ALU
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_y,
    output logic          zx,
    output logic          nx,
    output logic          zy,
    output logic          ny,
    output logic          f,
    output logic          no,
    input  logic [DW-1:0] alu_out,
    input  logic          zr,
    input  logic          ng,
    output logic [AW-1:0] pc
`ifdef HACK_HALT_DETECT_EN
    ,
    output logic          halted
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MREAD  = 3'd2,
        S_EXEC   = 3'd3,
        S_MWRITE = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t        state_q;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] d_q;
    logic [DW-1:0] m_q;
    logic [DW-1:0] r_q;
    logic          z_q;
    logic          n_q;
    logic [AW-1:0] pc_q;
    logic          instr_req_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [5:0]    ctrl_q;

    logic [AW-1:0] pc_inc_d;
    logic          jump_d;
    logic          halt_set;
    logic          halt_stop;

    // pc+1 wraps naturally at AW bits; jump uses the flags latched in EXEC
    assign pc_inc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
    assign jump_d   = (ir_q[2] & n_q) | (ir_q[1] & z_q) | (ir_q[0] & ~z_q & ~n_q);

`ifdef HACK_HALT_DETECT_EN
    logic halted_q;

    // an unconditional jump whose target is its own address can never make progress
    assign halt_set  = (ir_q[2:0] == 3'b111) && (a_q[AW-1:0] == pc_q);
    assign halt_stop = halted_q;
    assign halted    = halted_q;

    // sticky halt flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (state_q == S_WB && halt_set) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign halt_set  = 1'b0;
    assign halt_stop = 1'b0;
`endif

    // sequencer: state, architectural registers and registered handshake/ALU-control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            ir_q        <= '0;
            a_q         <= '0;
            d_q         <= '0;
            m_q         <= '0;
            r_q         <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            pc_q        <= '0;
            instr_req_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            ctrl_q      <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // only the first FETCH after reset (or a halt) arrives with req low
                    if (halt_stop) begin
                        instr_req_q <= 1'b0;
                    end else if (!instr_req_q) begin
                        instr_req_q <= 1'b1;
                    end else if (instr_ack) begin
                        ir_q        <= instr_data;
                        instr_req_q <= 1'b0;
                        state_q     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!ir_q[15]) begin
                        a_q         <= ir_q;
                        pc_q        <= pc_inc_d;
                        instr_req_q <= 1'b1;
                        state_q     <= S_FETCH;
                    end else if (ir_q[12]) begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        state_q   <= S_MREAD;
                    end else begin
                        ctrl_q  <= ir_q[11:6];
                        state_q <= S_EXEC;
                    end
                end
                S_MREAD: begin
                    if (mem_ack) begin
                        m_q       <= mem_rdata;
                        mem_req_q <= 1'b0;
                        ctrl_q    <= ir_q[11:6];
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_q    <= alu_out;
                    z_q    <= zr;
                    n_q    <= ng;
                    ctrl_q <= '0;
                    if (ir_q[3]) begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                        state_q   <= S_MWRITE;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MWRITE: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= S_WB;
                    end
                end
                S_WB: begin
                    if (ir_q[5]) a_q <= r_q;
                    if (ir_q[4]) d_q <= r_q;
                    // a_q on the right-hand side is still the pre-writeback value
                    pc_q        <= jump_d ? a_q[AW-1:0] : pc_inc_d;
                    instr_req_q <= ~halt_set;
                    state_q     <= S_FETCH;
                end
                default: begin
                    instr_req_q <= 1'b0;
                    mem_req_q   <= 1'b0;
                    mem_we_q    <= 1'b0;
                    ctrl_q      <= '0;
                    state_q     <= S_FETCH;
                end
            endcase
        end
    end

    assign instr_req  = instr_req_q;
    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = a_q[AW-1:0];
    assign mem_wdata  = r_q;
    assign alu_x      = d_q;
    assign alu_y      = ir_q[12] ? m_q : a_q;
    assign {zx, nx, zy, ny, f, no} = ctrl_q;

endmodule
